// File: rtl/debounce_pkg.sv
// Shared defaults and the width helper for the debounce bank.
package debounce_pkg;

  localparam int DEFAULT_MAX_COUNT   = 1000000;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Smallest r such that 2**r >= value; sizes a counter that must hold value-1.
  function automatic int clog2(input longint value);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Pin-side and user-side signals of the debounce bank.
interface debounce_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] bouncy;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_change;

  modport master (output bouncy, input debounced, input rise, input fall, input any_change);
  modport slave  (input bouncy, output debounced, output rise, output fall, output any_change);
endinterface

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser, disagreement counter, commit and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy,
  output logic debounced,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = clog2(longint'(MAX_COUNT) + 64'sd1);
  localparam logic [CNT_W-1:0] MAX_CNT_C = CNT_W'(MAX_COUNT);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   level_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   commit_s;
  logic                   deb_r;
  logic                   rise_r;
  logic                   fall_r;

  assign level_s = sync_r[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bouncy};
    end
  end

  // Any agreement clears the count, so a glitch earns no partial credit.
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    commit_s  = 1'b0;
    if (level_s != deb_r) begin
      if (cnt_r == MAX_CNT_C) begin
        commit_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Counter, committed level and one-cycle pulses; reset wins over a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      deb_r  <= INIT_LEVEL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      rise_r <= commit_s & level_s;
      fall_r <= commit_s & ~level_s;
      if (commit_s) begin
        deb_r <= level_s;
      end else begin
        deb_r <= deb_r;
      end
    end
  end

  assign debounced = deb_r;
  assign rise      = rise_r;
  assign fall      = fall_r;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced channels with a combined change strobe.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  debounce_bank_if.slave  bus
);

  logic [CHANNELS-1:0] deb_s;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .MAX_COUNT   (MAX_COUNT),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .bouncy    (bus.bouncy[i]),
      .debounced (deb_s[i]),
      .rise      (rise_s[i]),
      .fall      (fall_s[i])
    );
  end

  assign bus.debounced  = deb_s;
  assign bus.rise       = rise_s;
  assign bus.fall       = fall_s;
  // Built from registered pulses only, so it stays glitch-free and in step with them.
  assign bus.any_change = |(rise_s | fall_s);

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: expected commits are queued, a monitor checks them.
module tb_debounce_bank;

  localparam int CH  = 4;
  localparam int LAT = 7;

  typedef struct {
    int          cyc;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] deb;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  debounce_bank_if #(.CHANNELS(CH)) bus_if ();

  debounce_bank #(
    .CHANNELS    (CH),
    .MAX_COUNT   (4),
    .SYNC_STAGES (2),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_commit(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f,
                               input logic [CH-1:0] d);
    exp_t e;
    e.cyc = at; e.rise = r; e.fall = f; e.deb = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse cycle must match the oldest queued commit.
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      total++;
      if (bus_if.any_change !== |(bus_if.rise | bus_if.fall)) begin
        bad++;
        $display("FAIL any_change_or: got %b rise %b fall %b", bus_if.any_change, bus_if.rise, bus_if.fall);
      end
      if (bus_if.any_change === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: rise %b fall %b at cycle %0d, none expected",
                   bus_if.rise, bus_if.fall, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.cyc || bus_if.rise !== e.rise || bus_if.fall !== e.fall ||
              bus_if.debounced !== e.deb) begin
            bad++;
            $display("FAIL commit: cycle %0d rise %b fall %b deb %b, expected cycle %0d rise %b fall %b deb %b",
                     cyc, bus_if.rise, bus_if.fall, bus_if.debounced, e.cyc, e.rise, e.fall, e.deb);
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        total++;
        bad++;
        $display("FAIL missed_commit: expected at cycle %0d, now %0d", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int e0;
    cyc = 0; total = 0; bad = 0;
    rst = 1'b1;
    bus_if.bouncy = 4'b0000;

    // Reset state, then idle at INIT_LEVEL: no pulse may appear.
    tick(3);
    chk("rst_debounced", bus_if.debounced, 4'b0000);
    chk("rst_rise", bus_if.rise, 4'b0000);
    chk("rst_fall", bus_if.fall, 4'b0000);
    chk("rst_any", {3'b000, bus_if.any_change}, 4'b0000);
    rst = 1'b0;
    tick(10);
    chk("idle_debounced", bus_if.debounced, 4'b0000);

    // Clean step on channel 0.
    e0 = cyc;
    bus_if.bouncy[0] = 1'b1;
    expect_commit(e0 + LAT, 4'b0001, 4'b0000, 4'b0001);
    tick(LAT - 1);
    chk("step_before", bus_if.debounced, 4'b0000);
    tick(1);
    chk("step_after", bus_if.debounced, 4'b0001);
    chk("step_rise", bus_if.rise, 4'b0001);
    tick(1);
    chk("step_rise_done", bus_if.rise, 4'b0000);
    tick(8);

    // Two 4-cycle glitches on channel 1 are rejected, then a held high commits.
    repeat (2) begin
      bus_if.bouncy[1] = 1'b1;
      tick(4);
      bus_if.bouncy[1] = 1'b0;
      tick(4);
    end
    chk("glitch_rejected", bus_if.debounced, 4'b0001);
    e0 = cyc;
    bus_if.bouncy[1] = 1'b1;
    expect_commit(e0 + LAT, 4'b0010, 4'b0000, 4'b0011);
    tick(12);

    // Exactly five high cycles on channel 2 commits, then the return low falls.
    e0 = cyc;
    bus_if.bouncy[2] = 1'b1;
    expect_commit(e0 + LAT, 4'b0100, 4'b0000, 4'b0111);
    tick(5);
    bus_if.bouncy[2] = 1'b0;
    expect_commit(e0 + 5 + LAT, 4'b0000, 4'b0100, 4'b0011);
    tick(14);
    chk("boundary_final", bus_if.debounced, 4'b0011);

    // Simultaneous falls on 0/1, then simultaneous rises on 0/3.
    e0 = cyc;
    bus_if.bouncy = 4'b0000;
    expect_commit(e0 + LAT, 4'b0000, 4'b0011, 4'b0000);
    tick(12);
    e0 = cyc;
    bus_if.bouncy = 4'b1001;
    expect_commit(e0 + LAT, 4'b1001, 4'b0000, 4'b1001);
    tick(12);
    e0 = cyc;
    bus_if.bouncy = 4'b0000;
    expect_commit(e0 + LAT, 4'b0000, 4'b1001, 4'b0000);
    tick(12);

    // Reset while channel 0 counts at 3; a held input recommits after full latency.
    bus_if.bouncy[0] = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("midrst_debounced", bus_if.debounced, 4'b0000);
    chk("midrst_rise", bus_if.rise, 4'b0000);
    tick(2);
    chk("midrst_hold", bus_if.debounced, 4'b0000);
    rst = 1'b0;
    e0 = cyc;
    expect_commit(e0 + LAT, 4'b0001, 4'b0000, 4'b0001);
    tick(LAT - 1);
    chk("postrst_before", bus_if.debounced, 4'b0000);
    tick(6);
    chk("postrst_after", bus_if.debounced, 4'b0001);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_commits: %0d left, 0 expected", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel, parametrised switch/button debouncer with a built-in input synchroniser.
- Each channel commits a new level only after the synchronised input has disagreed with the committed level for a programmable number of consecutive cycles.
- Each channel also emits single-cycle rise and fall pulses.
- Sits between board pins (buttons, switches) and user logic; replaces the single-channel debouncer.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- MAX_COUNT, 1000000, disagreement cycles minus one required to commit a change (>=1).
- CNT_W, clog2(MAX_COUNT+1), counter width; derived, not overridden.
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2).
- INIT_LEVEL, 0, committed level and synchroniser contents after reset (0 or 1, all channels).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- bouncy  input  CHANNELS  raw asynchronous pin levels.
- debounced  output  CHANNELS  committed stable levels.
- rise  output  CHANNELS  one-cycle pulse when a channel commits 0->1.
- fall  output  CHANNELS  one-cycle pulse when a channel commits 1->0.
- any_change  output  1  OR of all rise and fall bits, same cycle.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, on the rst=1 edge:
  - all synchroniser flops = INIT_LEVEL
  - debounced = {CHANNELS{INIT_LEVEL}}
  - counters = 0
  - rise = fall = any_change = 0
- rst takes priority over everything, including a commit in the same cycle.
- Synchroniser: bouncy[i] passes through SYNC_STAGES flops; the last stage is s[i]. No combinational path from bouncy to any output.
- Per channel, each clk edge (rst=0):
  - s[i] == debounced[i]: cnt[i] <= 0; no pulse.
  - s[i] != debounced[i] and cnt[i] < MAX_COUNT: cnt[i] <= cnt[i]+1.
  - s[i] != debounced[i] and cnt[i] == MAX_COUNT: debounced[i] <= s[i]; cnt[i] <= 0; rise[i] <= s[i]; fall[i] <= ~s[i].
  - rise/fall are registered and high exactly one cycle, coincident with the first cycle debounced[i] shows the new value.
- Latency: a clean input step appears on debounced SYNC_STAGES + MAX_COUNT + 1 clk edges after the first edge that samples it.
- Glitch rejection: any return of s[i] to debounced[i] before the commit clears cnt[i]. The next disagreement restarts the count from 0; there is no partial credit.
- Counter never exceeds MAX_COUNT and never wraps. CNT_W must hold MAX_COUNT exactly; unsigned compare.
- Channels are fully independent. Simultaneous commits on several channels raise several rise/fall bits in the same cycle; any_change = |(rise|fall).
- Reset mid-count: the count is discarded and debounced returns to INIT_LEVEL. A held input then re-commits after the full latency from rst deassertion.
- Input held at INIT_LEVEL through and after reset: no pulse ever.

Decomposition:
- Package debounce_pkg:
  - default MAX_COUNT constant
  - clog2 function used to derive CNT_W
  - SYNC_STAGES default
- Sub-module debounce_channel: synchroniser + counter + commit + edge pulses for one bit, with the same parameters minus CHANNELS. debounce_bank instantiates CHANNELS copies via generate and ORs the pulses into any_change.

Test Plan:
- Reset/init: INIT_LEVEL=0, MAX_COUNT=4, SYNC_STAGES=2; hold bouncy=0, pulse rst -> debounced=0, rise=fall=any_change=0 throughout; counters 0.
- Clean step: bouncy[0] 0->1 at edge N -> debounced[0]=1 first visible after edge N+7; rise[0]=1 and any_change=1 for exactly that one cycle; fall stays 0.
- Glitch rejection: bouncy[1] high for 4 cycles then low (s disagrees 4 cycles, cnt reaches 3) -> no commit, no pulses. Repeat glitch; then hold high -> commit 7 cycles after the final rise.
- Boundary: bouncy[2] high for exactly 5 cycles (cnt reaches MAX_COUNT) -> commit occurs; fall pulse 7 cycles after it returns low and holds.
- Simultaneous: bouncy[0] and bouncy[3] rise on the same edge -> rise=4'b1001 in one cycle; any_change one cycle high.
- Reset mid-operation: bouncy[0] high, assert rst when cnt=3 -> debounced[0]=0, no rise. Keep bouncy=1, deassert rst -> commit 7 edges later, with rise pulse.
